// File: rtl/key_pulse_array.sv
// Per-channel key conditioner: synchroniser, debounce, press/release pulses, auto-repeat.
// Latency: SYNC_STAGES + DEBOUNCE cycles from a clean key edge to held/pulse/release_pulse.
// Backpressure: none; every output is a registered, free-running level or one-cycle event.
module key_pulse_array #(
    parameter int N            = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE     = 4,
    parameter int REPEAT_DELAY = 16,
    parameter int REPEAT_RATE  = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] key,
    input  logic [N-1:0] repeat_en,
    output logic [N-1:0] pulse,
    output logic [N-1:0] release_pulse,
    output logic [N-1:0] held
);

    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int DW   = $clog2(DEBOUNCE + 1);
    localparam int RW   = $clog2(RMAX + 1);

    localparam logic [DW-1:0] DCNT_LAST  = DW'(DEBOUNCE - 1);
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

    logic [N-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
    logic [N-1:0][DW-1:0]          dcnt_q, dcnt_d;
    logic [N-1:0][RW-1:0]          rcnt_q, rcnt_d;
    logic [N-1:0]                  held_q, held_d;
    logic [N-1:0]                  first_q, first_d;
    logic [N-1:0]                  pulse_q, pulse_d;
    logic [N-1:0]                  rel_q, rel_d;

    always_comb begin
        sync_d  = sync_q;
        dcnt_d  = dcnt_q;
        rcnt_d  = rcnt_q;
        held_d  = held_q;
        first_d = first_q;
        pulse_d = '0;
        rel_d   = '0;
        for (int i = 0; i < N; i++) begin
            sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], key[i]};

            // Any sample agreeing with held restarts the count, so bounces never leak through.
            if (sync_q[i][SYNC_STAGES-1] != held_q[i]) begin
                if (dcnt_q[i] == DCNT_LAST) begin
                    held_d[i] = sync_q[i][SYNC_STAGES-1];
                    dcnt_d[i] = '0;
                end else begin
                    dcnt_d[i] = dcnt_q[i] + DW'(1);
                end
            end else begin
                dcnt_d[i] = '0;
            end

            if (held_d[i] != held_q[i]) begin
                rcnt_d[i]  = '0;
                first_d[i] = 1'b1;
                pulse_d[i] = held_d[i];
                rel_d[i]   = ~held_d[i];
            end else if (held_q[i] && repeat_en[i]) begin
                if (first_q[i] && (rcnt_q[i] == DELAY_LAST)) begin
                    pulse_d[i] = 1'b1;
                    rcnt_d[i]  = '0;
                    first_d[i] = 1'b0;
                end else if (!first_q[i] && (rcnt_q[i] == RATE_LAST)) begin
                    pulse_d[i] = 1'b1;
                    rcnt_d[i]  = '0;
                end else begin
                    rcnt_d[i] = rcnt_q[i] + RW'(1);
                end
            end else begin
                // Released or repeat disabled: re-arm so the next repeat waits the full delay.
                rcnt_d[i]  = '0;
                first_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= '0;
            dcnt_q  <= '0;
            rcnt_q  <= '0;
            held_q  <= '0;
            first_q <= '1;
            pulse_q <= '0;
            rel_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            dcnt_q  <= dcnt_d;
            rcnt_q  <= rcnt_d;
            held_q  <= held_d;
            first_q <= first_d;
            pulse_q <= pulse_d;
            rel_q   <= rel_d;
        end
    end

    assign pulse         = pulse_q;
    assign release_pulse = rel_q;
    assign held          = held_q;

endmodule

// File: tb/tb_key_pulse_array.sv
// Bench for key_pulse_array: directed key sequences, expected events queued and matched by a monitor.
module tb_key_pulse_array;

    logic       clk;
    logic       reset;
    logic [3:0] key;
    logic [3:0] repeat_en;
    logic [3:0] pulse;
    logic [3:0] release_pulse;
    logic [3:0] held;

    key_pulse_array #(
        .N(4), .SYNC_STAGES(2), .DEBOUNCE(4), .REPEAT_DELAY(16), .REPEAT_RATE(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .key(key),
        .repeat_en(repeat_en),
        .pulse(pulse),
        .release_pulse(release_pulse),
        .held(held)
    );

    typedef struct {
        int         cyc;
        logic [3:0] p;
        logic [3:0] r;
        logic [3:0] h;
    } ev_t;

    ev_t q[$];
    int  cyc    = 0;
    int  n_cmp  = 0;
    int  n_bad  = 0;
    bit  done   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_ev(input int c, input logic [3:0] p, input logic [3:0] r, input logic [3:0] h);
        ev_t e;
        e.cyc = c;
        e.p   = p;
        e.r   = r;
        e.h   = h;
        q.push_back(e);
    endtask

    task automatic wait_until(input int x);
        while (cyc < x) @(negedge clk);
    endtask

    // Monitor: every pulse/release event must match the head of the expected queue.
    initial begin
        ev_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #2;
            if (!done && ((pulse | release_pulse) != 4'b0)) begin
                if (q.size() == 0) begin
                    chk("unexpected_event_pulse", int'(pulse), 0);
                    chk("unexpected_event_release", int'(release_pulse), 0);
                end else begin
                    e = q.pop_front();
                    chk("event_cycle", cyc, e.cyc);
                    chk("event_pulse", int'(pulse), int'(e.p));
                    chk("event_release", int'(release_pulse), int'(e.r));
                    chk("event_held", int'(held), int'(e.h));
                end
            end
        end
    end

    initial begin
        int c;
        int t;
        int r;
        reset     = 1'b0;
        key       = 4'b0;
        repeat_en = 4'b0;
        #3;
        chk("reset_pulse", int'(pulse), 0);
        chk("reset_release", int'(release_pulse), 0);
        chk("reset_held", int'(held), 0);
        @(negedge clk);
        reset = 1'b1;
        wait_until(cyc + 2);

        // Clean press on channel 0, no repeat: a single pulse 6 cycles after the key edge.
        c = cyc;
        key[0] = 1'b1;
        exp_ev(c + 6, 4'b0001, 4'b0000, 4'b0001);
        wait_until(c + 26);
        chk("press_held_level", int'(held), 1);

        // Release of channel 0.
        c = cyc;
        key[0] = 1'b0;
        exp_ev(c + 6, 4'b0000, 4'b0001, 4'b0000);
        wait_until(c + 12);

        // Bounce on channel 1: 3 high, 1 low, then steady high -> accepted 4 cycles after final rise at s.
        c = cyc;
        key[1] = 1'b1;
        exp_ev(c + 10, 4'b0010, 4'b0000, 4'b0010);
        wait_until(c + 3);
        key[1] = 1'b0;
        wait_until(c + 4);
        key[1] = 1'b1;
        wait_until(c + 16);
        c = cyc;
        key[1] = 1'b0;
        exp_ev(c + 6, 4'b0000, 4'b0010, 4'b0000);
        wait_until(c + 12);

        // Auto-repeat on channel 0, disabled then re-enabled mid-hold; rate slot coinciding with release yields release only.
        repeat_en = 4'b0001;
        c = cyc;
        key[0] = 1'b1;
        t = c + 6;
        exp_ev(t,      4'b0001, 4'b0000, 4'b0001);
        exp_ev(t + 16, 4'b0001, 4'b0000, 4'b0001);
        exp_ev(t + 20, 4'b0001, 4'b0000, 4'b0001);
        exp_ev(t + 24, 4'b0001, 4'b0000, 4'b0001);
        exp_ev(t + 28, 4'b0001, 4'b0000, 4'b0001);
        exp_ev(t + 32, 4'b0001, 4'b0000, 4'b0001);
        exp_ev(t + 56, 4'b0001, 4'b0000, 4'b0001);
        exp_ev(t + 60, 4'b0001, 4'b0000, 4'b0001);
        exp_ev(t + 64, 4'b0001, 4'b0000, 4'b0001);
        exp_ev(t + 68, 4'b0000, 4'b0001, 4'b0000);
        wait_until(t + 34);
        repeat_en = 4'b0000;
        wait_until(t + 40);
        repeat_en = 4'b0001;
        wait_until(t + 62);
        key[0] = 1'b0;
        wait_until(t + 74);
        repeat_en = 4'b0000;

        // Two channels pressed together.
        c = cyc;
        key = 4'b0101;
        exp_ev(c + 6, 4'b0101, 4'b0000, 4'b0101);
        wait_until(c + 12);
        chk("multi_held_level", int'(held), 5);
        c = cyc;
        key = 4'b0000;
        exp_ev(c + 6, 4'b0000, 4'b0101, 4'b0000);
        wait_until(c + 12);

        // Asynchronous reset while channel 2 repeats; key stays down so a fresh press follows.
        repeat_en = 4'b0100;
        c = cyc;
        key = 4'b0100;
        t = c + 6;
        exp_ev(t,      4'b0100, 4'b0000, 4'b0100);
        exp_ev(t + 16, 4'b0100, 4'b0000, 4'b0100);
        wait_until(t + 16);
        chk("pre_reset_pulse", int'(pulse), 4);
        #1 reset = 1'b0;
        #1;
        chk("async_reset_pulse", int'(pulse), 0);
        chk("async_reset_held", int'(held), 0);
        chk("async_reset_release", int'(release_pulse), 0);
        r = cyc + 2;
        wait_until(r);
        reset = 1'b1;
        r = cyc;
        exp_ev(r + 6,  4'b0100, 4'b0000, 4'b0100);
        exp_ev(r + 22, 4'b0100, 4'b0000, 4'b0100);
        exp_ev(r + 26, 4'b0100, 4'b0000, 4'b0100);
        exp_ev(r + 30, 4'b0000, 4'b0100, 4'b0000);
        wait_until(r + 24);
        key = 4'b0000;
        wait_until(r + 40);

        done = 1'b1;
        chk("events_outstanding", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/key_pulse_array.md
Name: key_pulse_array

Overview:
- N-channel conditioner for raw push-button/switch inputs. Each channel has a synchroniser, a debounce filter, single-cycle press and release pulses, and an optional per-channel auto-repeat mode.
- Sits between the board key pins (already inverted to active-high pressed) and the game/control FSMs that consume one-cycle "key pressed" events.
- Channels are fully independent and share only clk and reset.

Parameters:
- N, 4: number of key channels (>=1).
- SYNC_STAGES, 2: flip-flops in each input synchroniser (>=2).
- DEBOUNCE, 4: consecutive synchronised cycles a new level must persist before it is accepted (>=1).
- REPEAT_DELAY, 16: cycles from the press pulse to the first auto-repeat pulse (>=1).
- REPEAT_RATE, 4: cycles between subsequent auto-repeat pulses (>=1).

Ports:
- clk, input, 1: system clock; all state updates on posedge.
- reset, input, 1: asynchronous, active-low reset. Asserting it (0) clears all state immediately; state is released on the first posedge after it returns to 1.
- key, input, N: raw key levels, 1 = pressed, asynchronous to clk.
- repeat_en, input, N: per-channel auto-repeat enable, synchronous to clk.
- pulse, output, N: one-cycle press event, plus repeat events when enabled.
- release_pulse, output, N: one-cycle release event.
- held, output, N: debounced key level.

Behaviour:
- Reset (reset=0), asynchronous: synchroniser flops, held, pulse, release_pulse, debounce counters and repeat counters all go to 0; each channel's first flag goes to 1.
- All outputs are registered; there are no combinational paths from key to any output.
- Synchroniser: s[i] is key[i] delayed through SYNC_STAGES flops. Key high before posedge 1 gives s=1 after posedge SYNC_STAGES.
- Debounce counter dcnt, width $clog2(DEBOUNCE+1), evaluated each posedge:
  - s != held and dcnt == DEBOUNCE-1: held <= s, dcnt <= 0.
  - s != held otherwise: dcnt++.
  - s == held: dcnt <= 0. Any bounce restarts the count.
- Latency: a clean press seen before posedge 1 sets held=1 after posedge SYNC_STAGES+DEBOUNCE (6 with defaults). Release latency is identical.
- Press: on the edge where held goes 0->1, pulse[i] <= 1 for exactly one cycle. The repeat counter rcnt <= 0 and first <= 1.
- Release: on the edge where held goes 1->0, release_pulse[i] <= 1 for one cycle. rcnt <= 0, first <= 1, and no pulse is issued.
- Auto-repeat applies only while held=1, repeat_en=1 and no transition occurs that cycle. rcnt has width $clog2(max(REPEAT_DELAY,REPEAT_RATE)+1).
  - first=1 and rcnt == REPEAT_DELAY-1: pulse for one cycle, rcnt <= 0, first <= 0.
  - first=0 and rcnt == REPEAT_RATE-1: pulse for one cycle, rcnt <= 0.
  - Otherwise: rcnt++.
- Resulting pulse times: press edge t, then t+REPEAT_DELAY, then every REPEAT_RATE cycles after that.
- repeat_en=0 while held: rcnt <= 0, first <= 1, and no repeat pulses are issued. Re-enabling mid-hold restarts the full REPEAT_DELAY.
- REPEAT_RATE=1: pulse stays high every cycle after the first repeat. This is legal.
- Simultaneous events on different channels are handled independently, so pulses may coincide on the same cycle.
- Reset mid-hold: outputs drop at once. If the key is still down after reset is released, held rises SYNC_STAGES+DEBOUNCE cycles later and issues a fresh press pulse.
- A key held through the whole of reset is therefore reported as a new press.

Test Plan:
- Clean press, defaults, key=1 set before posedge 1 and held 20 cycles, repeat_en=0 -> held and pulse rise after posedge 6; pulse is high for exactly 1 cycle; no further pulses.
- Bounce: key high for 3 synchronised cycles, low for 1, then high steadily -> no pulse during the glitch; pulse appears 4 cycles after the final rise reaches s.
- Release: after the press above, drop key -> held falls and release_pulse is high for 1 cycle, 6 cycles after the drop; pulse stays 0.
- Auto-repeat, repeat_en[0]=1, key held 40 cycles, press pulse at cycle t -> further pulses at t+16, t+20, t+24, ... until release. Clearing repeat_en mid-hold stops them; setting it again gives the next pulse 16 cycles later.
- Multi-channel: key=4'b0101 applied simultaneously -> pulse=4'b0101 on the same cycle; channels 1 and 3 stay 0 throughout.
- Asynchronous reset: reset=0 between clock edges while key[2] is held with repeat active -> all outputs are 0 immediately. After reset=1 with key still held, a fresh press pulse appears after 6 cycles.
